pcie_rx_mem_req_decoder: RTL and testbench
==========================================

# pcie_rx_mem_req_decoder

Upstream stage of the PCIe-to-AXI-Lite bridge. It parses completer TLPs from the PCIe core's 64-bit RX AXI-Stream and presents one single-DW memory request at a time on the `mem_req_*` bus. The AXI-Lite write and read controllers consume that bus. Supported TLPs (1-DW MRd/MWr, 32- and 64-bit addressing) are decoded and held until accepted; all other TLPs are drained and counted.

## Interface
Parameters
- TCQ, 1, simulation clock-to-q delay on all register assignments
- C_DATA_WIDTH, 64, RX stream width; only 64 is supported

Ports
- m_axi_aclk  in  1  the single clock for the block
- m_axi_aresetn  in  1  reset, asynchronous assert, active-low
- s_axis_rx_tdata  in  64  TLP data; beat0 = {DW1,DW0}, beat1 = {DW3,DW2}, beat2 = {DW5,DW4}
- s_axis_rx_tkeep  in  8  byte qualifiers (ignored except for protocol checks in the bench)
- s_axis_rx_tlast  in  1  last beat of TLP
- s_axis_rx_tvalid  in  1  beat valid
- s_axis_rx_tready  out  1  beat accepted when tvalid & tready
- s_axis_rx_tuser  in  22  tuser[7:2] = BAR0..BAR5 hit (one-hot), tuser[8] = expansion ROM hit
- mem_req_valid  out  1  decoded request valid
- mem_req_ready  in  1  consumer accepts when valid & ready
- mem_req_bar_hit  out  3  encoded BAR: 0–5 = BAR0–5, 6 = expansion ROM
- mem_req_pcie_address  out  32  address DW (DW2 for 3DW header, DW3 for 4DW); bits [1:0] forced 0
- mem_req_byte_enable  out  4  first-DW BE, DW1[3:0]
- mem_req_write_readn  out  1  1 = MWr, 0 = MRd
- mem_req_phys_func  out  1  constant 0
- mem_req_write_data  out  32  payload DW for writes; 0 for reads
- mem_req_requester_id  out  16  DW1[31:16], for completion generation
- mem_req_tag  out  8  DW1[15:8]
- mem_req_tc  out  3  DW0[22:20]
- mem_req_attr  out  2  DW0[13:12]
- unsupported_count  out  16  saturating count of drained TLPs

## Operation
- Header fields: fmt = DW0[30:29], type = DW0[28:24], poison = DW0[14], length = DW0[9:0].
- The state machine is one-hot: IDLE, HDR2, HDR3, REQ, DRAIN.
- IDLE: on an accepted beat0, latch the DW0/DW1 fields and the BAR encoding from tuser. Go to HDR2. If tlast is set on beat0, go to DRAIN-complete (IDLE) and count the TLP.
- HDR2: on the accepted beat:
  - 3DW header: address = DW2. For MWr32, data = DW3.
  - 4DW header: address = DW3.
  - Go to REQ if the TLP is supported and complete (3DW). Go to HDR3 for a supported 4DW write. Otherwise go to DRAIN, or to IDLE if tlast.
- HDR3: the accepted beat supplies data = DW4. Go to REQ.
- Supported TLP = type 00000, length 1, at least one BAR or ROM hit, and not a poisoned write.
  - An MRd64 is complete at HDR2.
  - An unsupported TLP increments unsupported_count once, saturating at 16'hFFFF.
- REQ: mem_req_valid = 1, tready = 0, and outputs are stable. On mem_req_valid & mem_req_ready, go to IDLE.
- DRAIN: tready = 1. Discard beats until an accepted beat with tlast, then go to IDLE.
- Multiple BAR hit bits: the lowest index wins.
- A supported TLP whose tlast arrives earlier than its format requires is treated as unsupported.

## Timing
- Reset values while m_axi_aresetn is low:
  - state IDLE; s_axis_rx_tready 0; mem_req_valid 0; unsupported_count 0.
  - All mem_req_* data fields 0.
- tready becomes 1 on the first clock edge after reset release.
- tready is a registered function of next-state: 1 in IDLE, HDR2, HDR3 and DRAIN; 0 in REQ.
- Latency: the last required beat is accepted at edge N; mem_req_valid is 1 after edge N. After the handshake at edge M, mem_req_valid is 0 and tready is 1 after edge M.
- Back-to-back requests: at most one request per 3 cycles for 3DW TLPs, with no beat loss.
- tvalid low mid-TLP stalls the state machine with no state change.
- mem_req_ready held low keeps the request stable indefinitely.
- Reset asserted mid-TLP or in REQ aborts immediately. The remainder of a partially received TLP is not drained; the upstream core is also reset.

## Test plan
- MWr32 to BAR0: DW0 = 32'h40000001, BE = 4'hF, addr = 32'h00000104, data = 32'hDEADBEEF, tuser[2] = 1 → valid two cycles after beat0 with bar_hit 0, write_readn 1, address 32'h104, data 32'hDEADBEEF.
- MRd32 to BAR2, requester 16'h0100, tag 8'h2A, BE = 4'h3 → bar_hit 2, write_readn 0, requester_id 16'h0100, tag 8'h2A, byte_enable 4'h3, write_data 0.
- MWr64 with addr hi/lo = 0/32'h00000020 and data 32'h12345678, tuser[4] = 1 → address 32'h20, data 32'h12345678 after the third beat.
- MWr32 with length 2 (3 beats), then an MWr32 to BAR1 → no valid for the first TLP, unsupported_count = 1; the second TLP is decoded normally.
- Hold mem_req_ready low for 10 cycles during a request → tready 0, fields stable. Release → one handshake, then tready 1 on the next cycle.
- Assert reset between beat0 and beat1 → tready 0, valid 0, count 0. After release, a fresh MRd32 decodes correctly.

Source files
------------

// File: rtl/pcie_rx_mem_req_decoder_if.sv
// 64-bit PCIe RX AXI-Stream from the core plus the decoded single-DW memory request bus.
interface pcie_rx_mem_req_decoder_if;
    logic [63:0] s_axis_rx_tdata;
    logic [7:0]  s_axis_rx_tkeep;
    logic        s_axis_rx_tlast;
    logic        s_axis_rx_tvalid;
    logic        s_axis_rx_tready;
    logic [21:0] s_axis_rx_tuser;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [2:0]  mem_req_bar_hit;
    logic [31:0] mem_req_pcie_address;
    logic [3:0]  mem_req_byte_enable;
    logic        mem_req_write_readn;
    logic        mem_req_phys_func;
    logic [31:0] mem_req_write_data;
    logic [15:0] mem_req_requester_id;
    logic [7:0]  mem_req_tag;
    logic [2:0]  mem_req_tc;
    logic [1:0]  mem_req_attr;
    logic [15:0] unsupported_count;

    // master is the decoder: it sinks the RX stream and sources requests
    modport master (
        input  s_axis_rx_tdata, s_axis_rx_tkeep, s_axis_rx_tlast,
        input  s_axis_rx_tvalid, s_axis_rx_tuser,
        output s_axis_rx_tready,
        output mem_req_valid,
        input  mem_req_ready,
        output mem_req_bar_hit, mem_req_pcie_address, mem_req_byte_enable,
        output mem_req_write_readn, mem_req_phys_func, mem_req_write_data,
        output mem_req_requester_id, mem_req_tag, mem_req_tc, mem_req_attr,
        output unsupported_count
    );

    modport slave (
        output s_axis_rx_tdata, s_axis_rx_tkeep, s_axis_rx_tlast,
        output s_axis_rx_tvalid, s_axis_rx_tuser,
        input  s_axis_rx_tready,
        input  mem_req_valid,
        output mem_req_ready,
        input  mem_req_bar_hit, mem_req_pcie_address, mem_req_byte_enable,
        input  mem_req_write_readn, mem_req_phys_func, mem_req_write_data,
        input  mem_req_requester_id, mem_req_tag, mem_req_tc, mem_req_attr,
        input  unsupported_count
    );
endinterface

// File: rtl/pcie_rx_mem_req_decoder.sv
// Parses 1-DW MRd/MWr completer TLPs from the 64-bit PCIe RX stream and holds one
// decoded request on the mem_req bus; every other TLP is drained and counted.
module pcie_rx_mem_req_decoder #(
    parameter int TCQ          = 1,
    parameter int C_DATA_WIDTH = 64
) (
    input logic                       m_axi_aclk,
    input logic                       m_axi_aresetn,
    pcie_rx_mem_req_decoder_if.master bus
);

    if (C_DATA_WIDTH != 64 || TCQ < 0) begin : g_param_check
        $error("pcie_rx_mem_req_decoder: only C_DATA_WIDTH = 64 is supported");
    end

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        HDR2  = 5'b00010,
        HDR3  = 5'b00100,
        REQ   = 5'b01000,
        DRAIN = 5'b10000
    } state_t;

    state_t      state, state_nxt;

    logic        rx_tready;
    logic        rx_acc;
    logic        cnt_inc;
    logic [15:0] unsup_cnt;
    logic [31:0] dw_lo, dw_hi;
    logic [2:0]  bar_enc;
    logic        bar_any;

    // beat0 header fields kept for the supported-TLP decision on the next beat
    logic [1:0]  hdr_fmt;
    logic [4:0]  hdr_type;
    logic        hdr_poison;
    logic [9:0]  hdr_len;
    logic        hdr_bar_any;
    logic        hdr_ok;

    logic [2:0]  req_bar;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [15:0] req_rid;
    logic [7:0]  req_tag;
    logic [2:0]  req_tc;
    logic [1:0]  req_attr;

    assign dw_lo  = bus.s_axis_rx_tdata[31:0];
    assign dw_hi  = bus.s_axis_rx_tdata[63:32];
    assign rx_acc = bus.s_axis_rx_tvalid & rx_tready;

    // Lowest BAR index wins; ROM only when no BAR bit is set.
    always_comb begin
        bar_enc = 3'd6;
        for (int i = 5; i >= 0; i--) begin
            if (bus.s_axis_rx_tuser[2+i]) bar_enc = 3'(i);
        end
    end

    assign bar_any = |bus.s_axis_rx_tuser[8:2];

    assign hdr_ok = (hdr_type == 5'd0) && (hdr_len == 10'd1) && hdr_bar_any &&
                    !(hdr_fmt[1] && hdr_poison);

    always_comb begin
        state_nxt = state;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_acc) begin
                    if (bus.s_axis_rx_tlast) cnt_inc   = 1'b1;
                    else                     state_nxt = HDR2;
                end
            end
            HDR2: begin
                if (rx_acc) begin
                    if (!hdr_ok) begin
                        cnt_inc   = 1'b1;
                        state_nxt = bus.s_axis_rx_tlast ? IDLE : DRAIN;
                    end else if (hdr_fmt != 2'b11) begin
                        state_nxt = REQ;
                    end else if (bus.s_axis_rx_tlast) begin
                        // MWr64 missing its payload beat
                        cnt_inc   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = HDR3;
                    end
                end
            end
            HDR3: begin
                if (rx_acc) state_nxt = REQ;
            end
            REQ: begin
                if (bus.mem_req_ready) state_nxt = IDLE;
            end
            DRAIN: begin
                if (rx_acc && bus.s_axis_rx_tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state     <= IDLE;
            rx_tready <= 1'b0;
            unsup_cnt <= 16'd0;
        end else begin
            state     <= state_nxt;
            rx_tready <= (state_nxt != REQ);
            if (cnt_inc && unsup_cnt != 16'hFFFF) unsup_cnt <= unsup_cnt + 16'd1;
        end
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            hdr_fmt     <= 2'd0;
            hdr_type    <= 5'd0;
            hdr_poison  <= 1'b0;
            hdr_len     <= 10'd0;
            hdr_bar_any <= 1'b0;
            req_bar     <= 3'd0;
            req_addr    <= 32'd0;
            req_be      <= 4'd0;
            req_wdata   <= 32'd0;
            req_rid     <= 16'd0;
            req_tag     <= 8'd0;
            req_tc      <= 3'd0;
            req_attr    <= 2'd0;
        end else if (rx_acc) begin
            case (state)
                IDLE: begin
                    hdr_fmt     <= dw_lo[30:29];
                    hdr_type    <= dw_lo[28:24];
                    hdr_poison  <= dw_lo[14];
                    hdr_len     <= dw_lo[9:0];
                    hdr_bar_any <= bar_any;
                    req_tc      <= dw_lo[22:20];
                    req_attr    <= dw_lo[13:12];
                    req_be      <= dw_hi[3:0];
                    req_tag     <= dw_hi[15:8];
                    req_rid     <= dw_hi[31:16];
                    req_bar     <= bar_enc;
                end
                HDR2: begin
                    req_addr  <= hdr_fmt[0] ? {dw_hi[31:2], 2'b00} : {dw_lo[31:2], 2'b00};
                    req_wdata <= (hdr_fmt == 2'b10) ? dw_hi : 32'd0;
                end
                HDR3:    req_wdata <= dw_lo;
                default: ;
            endcase
        end
    end

    assign bus.s_axis_rx_tready     = rx_tready;
    assign bus.mem_req_valid        = (state == REQ);
    assign bus.mem_req_bar_hit      = req_bar;
    assign bus.mem_req_pcie_address = req_addr;
    assign bus.mem_req_byte_enable  = req_be;
    assign bus.mem_req_write_readn  = hdr_fmt[1];
    assign bus.mem_req_phys_func    = 1'b0;
    assign bus.mem_req_write_data   = req_wdata;
    assign bus.mem_req_requester_id = req_rid;
    assign bus.mem_req_tag          = req_tag;
    assign bus.mem_req_tc           = req_tc;
    assign bus.mem_req_attr         = req_attr;
    assign bus.unsupported_count    = unsup_cnt;

    logic unused_ok;
    assign unused_ok = ^{bus.s_axis_rx_tkeep, bus.s_axis_rx_tuser[21:9], bus.s_axis_rx_tuser[1:0]};

endmodule

// File: tb/tb_pcie_rx_mem_req_decoder.sv
// Bench for pcie_rx_mem_req_decoder: directed vector table, hand-written corner
// sequences and randomized TLPs checked against a spec-level reference model.
module tb_pcie_rx_mem_req_decoder;

  logic clk, rstn;
  pcie_rx_mem_req_decoder_if bus ();

  pcie_rx_mem_req_decoder #(.TCQ(1), .C_DATA_WIDTH(64)) dut (
    .m_axi_aclk   (clk),
    .m_axi_aresetn(rstn),
    .bus          (bus)
  );

  typedef struct packed {
    logic [2:0]  bar;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        wr;
    logic [31:0] data;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [1:0]  attr;
  } req_t;

  typedef struct {
    string       name;
    logic [31:0] dw [8];
    int          nb;
    logic [21:0] user;
    bit          ev;
    req_t        exp;
  } vec_t;

  vec_t vecs [$];
  int checks = 0, failures = 0, exp_cnt = 0, cyc = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time expired, want TB_RESULT first");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_req(input string t, input req_t e);
    chk({t, ".valid"}, 32'(bus.mem_req_valid), 32'd1);
    chk({t, ".bar"},   32'(bus.mem_req_bar_hit), 32'(e.bar));
    chk({t, ".addr"},  bus.mem_req_pcie_address, e.addr);
    chk({t, ".be"},    32'(bus.mem_req_byte_enable), 32'(e.be));
    chk({t, ".wr"},    32'(bus.mem_req_write_readn), 32'(e.wr));
    chk({t, ".data"},  bus.mem_req_write_data, e.data);
    chk({t, ".rid"},   32'(bus.mem_req_requester_id), 32'(e.rid));
    chk({t, ".tag"},   32'(bus.mem_req_tag), 32'(e.tag));
    chk({t, ".tc"},    32'(bus.mem_req_tc), 32'(e.tc));
    chk({t, ".attr"},  32'(bus.mem_req_attr), 32'(e.attr));
    chk({t, ".pf"},    32'(bus.mem_req_phys_func), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_beat(input logic [63:0] d, input logic [21:0] u, input logic last, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    bus.s_axis_rx_tdata  = d;
    bus.s_axis_rx_tuser  = u;
    bus.s_axis_rx_tlast  = last;
    bus.s_axis_rx_tkeep  = 8'hFF;
    bus.s_axis_rx_tvalid = 1'b1;
    n = 0;
    while (bus.s_axis_rx_tready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      checks++;
      failures++;
      $display("FAIL beat_accept: tready %b after 64 cycles, want 1", bus.s_axis_rx_tready);
    end else begin
      @(negedge clk);
    end
    bus.s_axis_rx_tvalid = 1'b0;
    bus.s_axis_rx_tlast  = 1'b0;
  endtask

  task automatic send_tlp(input logic [31:0] dw [8], input int nb, input logic [21:0] u, input int gap);
    for (int b = 0; b < nb; b++)
      send_beat({dw[2*b+1], dw[2*b]}, u, (b == nb - 1), gap);
  endtask

  task automatic take_req(input req_t e, input int hold, input string t);
    repeat (hold) begin
      @(negedge clk);
      check_req({t, ".hold"}, e);
      chk({t, ".hold_tready"}, 32'(bus.s_axis_rx_tready), 32'd0);
    end
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    chk({t, ".done_valid"}, 32'(bus.mem_req_valid), 32'd0);
    chk({t, ".done_tready"}, 32'(bus.s_axis_rx_tready), 32'd1);
  endtask

  // Reference model straight from the TLP rules: returns 1 for a supported request.
  function automatic bit model(input logic [31:0] dw [8], input int nb, input logic [21:0] u, output req_t e);
    int  hdr, need, bar;
    bit  wr, found;
    wr   = dw[0][30];
    hdr  = dw[0][29] ? 4 : 3;
    need = (hdr + (wr ? int'(dw[0][9:0]) : 0) + 1) / 2;
    bar = 6;
    found = 0;
    for (int i = 0; i < 6; i++)
      if (!found && u[2+i]) begin bar = i; found = 1; end
    e.bar  = 3'(bar);
    e.addr = dw[hdr-1] & 32'hFFFF_FFFC;
    e.be   = dw[1][3:0];
    e.wr   = wr;
    e.data = wr ? dw[hdr] : 32'h0;
    e.rid  = dw[1][31:16];
    e.tag  = dw[1][15:8];
    e.tc   = dw[0][22:20];
    e.attr = dw[0][13:12];
    return (dw[0][28:24] == 5'd0) && (dw[0][9:0] == 10'd1) && (u[8:2] != 7'd0) &&
           !(wr && dw[0][14]) && (nb >= need);
  endfunction

  task automatic add_vec(input string n, input logic [31:0] d0, d1, d2, d3, d4,
                         input int nb, input logic [21:0] u, input bit ev, input req_t e);
    vec_t v;
    v.name = n;
    v.dw   = '{d0, d1, d2, d3, d4, 32'h0, 32'h0, 32'h0};
    v.nb   = nb;
    v.user = u;
    v.ev   = ev;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  req_t        e;
  bit          sup;
  int          nb, hdr, full, t0;
  logic [1:0]  fmt;
  logic [4:0]  typ;
  logic [9:0]  len;
  logic        poi;
  logic [21:0] usr;
  logic [31:0] rdw [8];

  initial begin
    // name, DW0..DW4, beats, tuser, expect request, {bar,addr,be,wr,data,rid,tag,tc,attr}
    add_vec("mwr32_bar0", 32'h40000001, 32'h0000000F, 32'h00000104, 32'hDEADBEEF, 0, 2, 22'h004, 1,
            '{3'd0, 32'h104, 4'hF, 1'b1, 32'hDEADBEEF, 16'h0, 8'h0, 3'd0, 2'd0});
    add_vec("mrd32_bar2", 32'h00000001, 32'h01002A03, 32'h00002000, 0, 0, 2, 22'h010, 1,
            '{3'd2, 32'h2000, 4'h3, 1'b0, 32'h0, 16'h0100, 8'h2A, 3'd0, 2'd0});
    add_vec("mwr64_bar2", 32'h60000001, 32'h0000000F, 32'h0, 32'h00000020, 32'h12345678, 3, 22'h010, 1,
            '{3'd2, 32'h20, 4'hF, 1'b1, 32'h12345678, 16'h0, 8'h0, 3'd0, 2'd0});
    add_vec("mwr32_len2", 32'h40000002, 32'h0000000F, 32'h100, 32'h11111111, 32'h22222222, 3, 22'h008, 0, '0);
    add_vec("mwr32_bar1", 32'h40000001, 32'hABCD5507, 32'h00001003, 32'hCAFEF00D, 0, 2, 22'h008, 1,
            '{3'd1, 32'h1000, 4'h7, 1'b1, 32'hCAFEF00D, 16'hABCD, 8'h55, 3'd0, 2'd0});
    add_vec("mrd64_rom", 32'h20502001, 32'h12347F0C, 32'h00000001, 32'h80000ABC, 0, 2, 22'h100, 1,
            '{3'd6, 32'h80000ABC, 4'hC, 1'b0, 32'h0, 16'h1234, 8'h7F, 3'd5, 2'd2});
    add_vec("multi_bar", 32'h00000001, 32'h0000010F, 32'h00000FFF, 0, 0, 2, 22'h028, 1,
            '{3'd1, 32'hFFC, 4'hF, 1'b0, 32'h0, 16'h0, 8'h01, 3'd0, 2'd0});
    add_vec("poison_mwr", 32'h40004001, 32'h0000000F, 32'h200, 32'h33333333, 0, 2, 22'h004, 0, '0);
    add_vec("poison_mrd", 32'h00004001, 32'h0000000F, 32'h300, 0, 0, 2, 22'h004, 1,
            '{3'd0, 32'h300, 4'hF, 1'b0, 32'h0, 16'h0, 8'h0, 3'd0, 2'd0});
    add_vec("no_bar", 32'h00000001, 32'h0000000F, 32'h400, 0, 0, 2, 22'h200003, 0, '0);
    add_vec("cpld", 32'h4A000001, 32'h0, 32'h0, 32'h44444444, 0, 2, 22'h004, 0, '0);
    add_vec("mwr64_trunc", 32'h60000001, 32'h0000000F, 32'h0, 32'h500, 0, 2, 22'h004, 0, '0);
    add_vec("mrd32_trunc", 32'h00000001, 32'h0000000F, 0, 0, 0, 1, 22'h004, 0, '0);
    add_vec("mwr32_bar5", 32'h40701001, 32'hFFFFFF01, 32'h7FFFFFFF, 32'h00000001, 0, 2, 22'h180, 1,
            '{3'd5, 32'h7FFFFFFC, 4'h1, 1'b1, 32'h1, 16'hFFFF, 8'hFF, 3'd7, 2'd1});

    rstn = 1'b0;
    bus.s_axis_rx_tdata  = '0;
    bus.s_axis_rx_tkeep  = '0;
    bus.s_axis_rx_tlast  = 1'b0;
    bus.s_axis_rx_tvalid = 1'b0;
    bus.s_axis_rx_tuser  = '0;
    bus.mem_req_ready    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.tready", 32'(bus.s_axis_rx_tready), 32'd0);
    chk("rst.valid",  32'(bus.mem_req_valid), 32'd0);
    chk("rst.count",  32'(bus.unsupported_count), 32'd0);
    chk("rst.addr",   bus.mem_req_pcie_address, 32'd0);
    chk("rst.data",   bus.mem_req_write_data, 32'd0);
    chk("rst.rid",    32'(bus.mem_req_requester_id), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rel.tready", 32'(bus.s_axis_rx_tready), 32'd1);

    for (int k = 0; k < vecs.size(); k++) begin
      send_tlp(vecs[k].dw, vecs[k].nb, vecs[k].user, 0);
      if (vecs[k].ev) begin
        check_req(vecs[k].name, vecs[k].exp);
        take_req(vecs[k].exp, 0, vecs[k].name);
      end else begin
        exp_cnt++;
        chk({vecs[k].name, ".valid_n"}, 32'(bus.mem_req_valid), 32'd0);
      end
      chk({vecs[k].name, ".count"}, 32'(bus.unsupported_count), 32'(exp_cnt));
    end

    // Request held for 10 cycles with ready low, then one handshake.
    send_tlp(vecs[0].dw, 2, 22'h004, 0);
    check_req("hold10", vecs[0].exp);
    take_req(vecs[0].exp, 10, "hold10");

    // Back-to-back MRd32 with ready high: one request every 3 cycles.
    bus.mem_req_ready = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 3; k++) begin
      rdw = '{32'h00000001, 32'h0000000F, 32'h1000 + 32'(k * 16), 0, 0, 0, 0, 0};
      send_tlp(rdw, 2, 22'h004, 0);
      check_req($sformatf("b2b%0d", k),
                '{3'd0, 32'h1000 + 32'(k * 16), 4'hF, 1'b0, 32'h0, 16'h0, 8'h0, 3'd0, 2'd0});
    end
    chk("b2b.cycles", 32'(cyc - t0), 32'd8);
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    chk("b2b.valid_n", 32'(bus.mem_req_valid), 32'd0);

    // Reset between beat0 and beat1 of an MWr32.
    send_beat({32'h0000000F, 32'h40000001}, 22'h004, 1'b0, 0);
    rstn = 1'b0;
    #1;
    chk("midrst.tready", 32'(bus.s_axis_rx_tready), 32'd0);
    chk("midrst.valid",  32'(bus.mem_req_valid), 32'd0);
    chk("midrst.count",  32'(bus.unsupported_count), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    chk("midrst.rel_tready", 32'(bus.s_axis_rx_tready), 32'd1);
    send_tlp(vecs[1].dw, 2, vecs[1].user, 0);
    check_req("midrst.mrd", vecs[1].exp);
    take_req(vecs[1].exp, 1, "midrst.mrd");
    chk("midrst.count2", 32'(bus.unsupported_count), 32'd0);

    // Randomized TLPs against the reference model.
    for (int t = 0; t < 150; t++) begin
      fmt = 2'($urandom_range(0, 3));
      typ = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      len = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(2, 3)) : 10'd1;
      poi = ($urandom_range(0, 7) == 0);
      usr = 22'($urandom);
      if ($urandom_range(0, 7) == 0) usr = usr & ~22'h1FC;
      rdw[0] = {1'b0, fmt, typ, 1'b0, 3'($urandom), 4'($urandom), 1'b0, poi, 2'($urandom), 2'b00, len};
      for (int i = 1; i < 8; i++) rdw[i] = $urandom;
      hdr  = fmt[0] ? 4 : 3;
      full = (hdr + (fmt[1] ? int'(len) : 0) + 1) / 2;
      nb   = full;
      if (full > 1 && $urandom_range(0, 7) == 0) nb = $urandom_range(1, full - 1);
      sup = model(rdw, nb, usr, e);
      send_tlp(rdw, nb, usr, $urandom_range(0, 1));
      if (sup) begin
        check_req("rnd", e);
        take_req(e, $urandom_range(0, 3), "rnd");
      end else begin
        exp_cnt++;
        chk("rnd.valid_n", 32'(bus.mem_req_valid), 32'd0);
      end
      chk("rnd.count", 32'(bus.unsupported_count), 32'(exp_cnt));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
